// File: rtl/arpeggio_sequencer_if.sv
// Control/status bundle between a host and the arpeggio sequencer.
// No valid/ready: arp_toggle is a one-cycle request pulse; addr_tick and note_change are one-cycle strobes.
interface arpeggio_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        base;
    logic [1:0]        mode;
    logic              arp_toggle;
    logic [ADDR_W-1:0] addr;
    logic              addr_tick;
    logic [2:0]        note_idx;
    logic              arp_active;
    logic              note_change;
    logic              dir_dbg;

    modport master (
        output base, mode, arp_toggle,
        input  addr, addr_tick, note_idx, arp_active, note_change, dir_dbg
    );

    modport slave (
        input  base, mode, arp_toggle,
        output addr, addr_tick, note_idx, arp_active, note_change, dir_dbg
    );
endinterface

// File: rtl/arpeggio_sequencer.sv
// Arpeggio sequencer: wave-table address generator whose tick period follows a stepped note pattern.
// The period reloads only at divider wraps so the tone stays phase-continuous across note changes.
module arpeggio_sequencer #(
    parameter int          NOTES       = 4,
    parameter int          STEP_CYCLES = 50000000,
    parameter logic [31:0] RATIOS      = {4'd8, 4'd6, 4'd5, 4'd4},
    parameter int          BASE_OFFSET = 746,
    parameter int          ADDR_W      = 8,
    parameter int          PERIOD_W    = 14
) (
    input  logic                CLK100MHZ,
    input  logic                RESET,
    arpeggio_sequencer_if.slave bus
);
    localparam int                STEP_W    = $clog2(STEP_CYCLES);
    localparam int                PROD_W    = PERIOD_W + 4;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NOTES - 1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic [PERIOD_W-1:0] base_period_q;
    logic [PERIOD_W-1:0] div_cnt_q;
    logic [PERIOD_W-1:0] active_period_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_tick_q;
    logic [3:0]          ratio;
    logic [PROD_W-1:0]   product;
    logic [PERIOD_W-1:0] target_period;
    logic                div_wrap;

    logic                arp_active_q, arp_active_d;
    logic [2:0]          note_idx_q, note_idx_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    dir_e                dir_q, dir_d;
    logic                note_change_q, note_change_d;

    // Ratios are in quarters, so the product is scaled back by dropping two LSBs.
    always_comb begin
        ratio = 4'd0;
        for (int k = 0; k < NOTES; k++) begin
            if (note_idx_q == 3'(k)) ratio = RATIOS[4*k +: 4];
        end
        product       = PROD_W'(base_period_q) * PROD_W'(ratio);
        target_period = product[PERIOD_W+1:2];
        if (target_period == '0) target_period = PERIOD_W'(1);
    end

    assign div_wrap = (div_cnt_q == active_period_q - PERIOD_W'(1));

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            base_period_q   <= PERIOD_W'(BASE_OFFSET);
            div_cnt_q       <= '0;
            active_period_q <= PERIOD_W'(1);
            addr_q          <= '0;
            addr_tick_q     <= 1'b0;
        end else begin
            base_period_q <= PERIOD_W'(BASE_OFFSET) + PERIOD_W'(bus.base);
            addr_tick_q   <= div_wrap;
            if (div_wrap) begin
                div_cnt_q       <= '0;
                addr_q          <= addr_q + ADDR_W'(1);
                active_period_q <= target_period;
            end else begin
                div_cnt_q <= div_cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            arp_active_q  <= 1'b0;
            note_idx_q    <= '0;
            step_cnt_q    <= '0;
            dir_q         <= DIR_UP;
            note_change_q <= 1'b0;
        end else begin
            arp_active_q  <= arp_active_d;
            note_idx_q    <= note_idx_d;
            step_cnt_q    <= step_cnt_d;
            dir_q         <= dir_d;
            note_change_q <= note_change_d;
        end
    end

    // A disabling toggle takes priority over a coinciding step boundary.
    always_comb begin
        arp_active_d  = arp_active_q ^ bus.arp_toggle;
        note_idx_d    = note_idx_q;
        step_cnt_d    = step_cnt_q;
        dir_d         = (bus.mode == 2'd3) ? dir_q : DIR_UP;
        note_change_d = 1'b0;
        if (!arp_active_d || !arp_active_q) begin
            note_idx_d = '0;
            step_cnt_d = '0;
            dir_d      = DIR_UP;
        end else if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            case (bus.mode)
                2'd1: note_idx_d = (note_idx_q == LAST_IDX) ? 3'd0 : note_idx_q + 3'd1;
                2'd2: note_idx_d = (note_idx_q == 3'd0) ? LAST_IDX : note_idx_q - 3'd1;
                2'd3: begin
                    if (dir_q == DIR_UP) begin
                        if (note_idx_q == LAST_IDX) begin
                            dir_d      = DIR_DOWN;
                            note_idx_d = note_idx_q - 3'd1;
                        end else begin
                            note_idx_d = note_idx_q + 3'd1;
                        end
                    end else begin
                        if (note_idx_q == 3'd0) begin
                            dir_d      = DIR_UP;
                            note_idx_d = note_idx_q + 3'd1;
                        end else begin
                            note_idx_d = note_idx_q - 3'd1;
                        end
                    end
                end
                default: note_idx_d = note_idx_q;
            endcase
            note_change_d = (note_idx_d != note_idx_q);
        end else begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
        end
    end

    assign bus.addr        = addr_q;
    assign bus.addr_tick   = addr_tick_q;
    assign bus.note_idx    = note_idx_q;
    assign bus.arp_active  = arp_active_q;
    assign bus.note_change = note_change_q;
    assign bus.dir_dbg     = dir_q;
endmodule

// File: doc/arpeggio_sequencer.md
ARPEGGIO_SEQUENCER -- requirements
Module: arpeggio_sequencer

Interface
REQ-001 SHALL have parameter NOTES, default 4, number of notes in the pattern; legal range 2..8.
REQ-002 SHALL have parameter STEP_CYCLES, default 50000000, clock cycles per note step; legal minimum 2.
REQ-003 SHALL have parameter RATIOS, default {4'd8,4'd6,4'd5,4'd4}, packed 4-bit period multipliers in quarters; entry k occupies bits [4k+3:4k].
REQ-004 SHALL have parameter BASE_OFFSET, default 746, added to the base input to form the base period.
REQ-005 SHALL have parameter ADDR_W, default 8, wave-table address width.
REQ-006 SHALL have parameter PERIOD_W, default 14, divider period width.
REQ-007 CLK100MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-008 RESET  input  1  asynchronous, active-high reset.
REQ-009 base  input  8  base-pitch select, sampled every cycle.
REQ-010 mode  input  2  pattern order: 0 hold, 1 up, 2 down, 3 up-down.
REQ-011 arp_toggle  input  1  single-cycle pulse; toggles arpeggiator enable.
REQ-012 addr  output  ADDR_W  wave-table read address.
REQ-013 addr_tick  output  1  one-cycle pulse on each addr advance.
REQ-014 note_idx  output  3  current pattern index.
REQ-015 arp_active  output  1  arpeggiator enabled.
REQ-016 note_change  output  1  one-cycle pulse on each note_idx change.

Function
REQ-017 SHALL register base_period = BASE_OFFSET + base each cycle, PERIOD_W wide, no overflow for defaults.
REQ-018 SHALL compute target period = (base_period * RATIOS[note_idx]) >> 2 at full product width, truncated to PERIOD_W bits; a result of 0 SHALL be clamped to 1.
REQ-019 Divider: counter div_cnt runs 0..active_period-1; at active_period-1 it SHALL assert addr_tick for one cycle, increment addr modulo 2^ADDR_W, clear div_cnt, and load active_period from target period.
REQ-020 Period changes (note or base) SHALL take effect only at a divider wrap, so the tone is phase-continuous.
REQ-021 arp_toggle SHALL flip arp_active one cycle after the pulse.
REQ-022 When arp_active=0: note_idx=0; step_cnt held at 0; note_change=0.
REQ-023 When arp_active=1: step_cnt SHALL count 0..STEP_CYCLES-1; at STEP_CYCLES-1 it SHALL wrap to 0 and advance note_idx per mode, with note_change=1 that cycle when the index changes.
REQ-024 Up SHALL step 0,1,...,NOTES-1,0. Down SHALL step NOTES-1,...,0,NOTES-1; from index 0 the first step goes to NOTES-1. Hold SHALL keep note_idx unchanged with no note_change.
REQ-025 Up-down SHALL ping-pong without repeating endpoints, e.g. 0,1,2,3,2,1,0,1 for NOTES=4. An internal direction flag SHALL start at up and reverse at 0 and NOTES-1.
REQ-026 A mode change SHALL take effect at the next step boundary; the direction flag SHALL reset to up whenever mode is not 3.
REQ-027 A toggle that disables the arpeggiator on the same cycle as a step boundary SHALL win: note_idx goes to 0, step_cnt goes to 0, and there is no note_change pulse.
REQ-028 Enabling SHALL start at note_idx=0 with step_cnt=0.

Reset
REQ-029 RESET SHALL immediately force: addr=0, addr_tick=0, div_cnt=0, active_period=1, note_idx=0, step_cnt=0, direction=up, arp_active=0, note_change=0, base_period=BASE_OFFSET.
REQ-030 After RESET falls, the first addr_tick SHALL occur on the first rising edge; subsequent ticks follow the target period.
REQ-031 RESET asserted mid-step or mid-period SHALL abandon all progress without emitting any partial pulse.

Verification (bench parameters: NOTES=4, STEP_CYCLES=10, BASE_OFFSET=2, base=2 -> base_period=4, periods 4,5,6,8)
REQ-032 Idle tone: release reset, arp off -> addr_tick every 4 cycles; addr wraps 255->0 after 256 ticks.
REQ-033 Up pattern: mode=1, pulse arp_toggle -> note_idx 0,1,2,3,0 every 10 cycles, one note_change per step; tick spacing moves to 5, 6, 8 only after the first wrap in each step.
REQ-034 Up-down and down: mode=3 -> 0,1,2,3,2,1,0,1; switch to mode=2 mid-step -> change applies at the next boundary and descends from there.
REQ-035 Collision: arp_toggle coincides with the step boundary while active -> arp_active=0, note_idx=0, note_change stays 0.
REQ-036 Reset mid-run: assert RESET during note 2 with div_cnt=3 -> all outputs at reset values within the same cycle; no addr_tick emitted.
